// File: rtl/usart_rx_if.sv
// rtl/usart_rx_if.sv - byte holding-register handshake between usart_rx and its consumer
interface usart_rx_if;
    logic [7:0] data;
    logic       data_ready;
    logic       data_ack;
    logic       overrun;
    logic       frame_error;
    logic       busy;

    modport master (
        output data, data_ready, overrun, frame_error, busy,
        input  data_ack
    );

    modport slave (
        input  data, data_ready, overrun, frame_error, busy,
        output data_ack
    );
endinterface

// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - 8N1 serial receiver with level-valid/ack holding register
// USART_RX_PARITY_EN selects 8E1 framing with a PARITY state.
module usart_rx #(
    parameter int CLK_FREQ = 70000000,
    parameter int BAUD     = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    usart_rx_if.master  bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);

`ifdef USART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          data_ready_q, data_ready_d;
    logic          overrun_q, overrun_d;
    logic          frame_error_q, frame_error_d;
    logic          busy_q, busy_d;
`ifdef USART_RX_PARITY_EN
    logic          parity_ok_q, parity_ok_d;
`endif
    logic          commit;
    logic          ack;

    always_comb begin
        rx_meta_d     = rx;
        rx_s_d        = rx_meta_q;
        state_d       = state_q;
        timer_d       = timer_q + TW'(1);
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_ready_d  = data_ready_q;
        overrun_d     = overrun_q;
        frame_error_d = 1'b0;
`ifdef USART_RX_PARITY_EN
        parity_ok_d   = parity_ok_q;
`endif
        commit        = 1'b0;
        ack           = bus.data_ack && data_ready_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: if (timer_q == HALF_LAST) begin
                // a start bit that has gone high again by mid-bit is line noise
                timer_d   = '0;
                bit_cnt_d = '0;
                state_d   = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (timer_q == BIT_LAST) begin
                timer_d   = '0;
                shift_d   = {rx_s_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
`ifdef USART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef USART_RX_PARITY_EN
            S_PARITY: if (timer_q == BIT_LAST) begin
                timer_d     = '0;
                parity_ok_d = ~(^shift_q ^ rx_s_q);
                state_d     = S_STOP;
            end
`endif
            S_STOP: if (timer_q == BIT_LAST) begin
                timer_d = '0;
                if (!rx_s_q) begin
                    frame_error_d = 1'b1;
                    state_d       = S_BREAK;
                end
`ifdef USART_RX_PARITY_EN
                else if (!parity_ok_q) begin
                    frame_error_d = 1'b1;
                    state_d       = S_IDLE;
                end
`endif
                else begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // a byte landing in the same cycle as an ack replaces the acked one
        if (commit) begin
            data_d       = shift_q;
            data_ready_d = 1'b1;
            if (data_ready_q && !bus.data_ack) overrun_d = 1'b1;
            else if (ack)                      overrun_d = 1'b0;
        end else if (ack) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_ready_q  <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef USART_RX_PARITY_EN
            parity_ok_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_ready_q  <= data_ready_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
`ifdef USART_RX_PARITY_EN
            parity_ok_q   <= parity_ok_d;
`endif
        end
    end

    assign bus.data        = data_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_usart_rx.sv
// tb/tb_usart_rx.sv - directed and randomized frame checks for usart_rx
module tb_usart_rx;
    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef USART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT = 2 + DIV / 2 + (9 + PAR_BITS) * DIV + 1;

    logic clock = 1'b0;
    logic reset;
    logic rx;
    int   checks   = 0;
    int   failures = 0;
    int   fe_seen  = 0;
    int   fe_base;

    usart_rx_if bus ();

    usart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (bus.frame_error === 1'b1) fe_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic send_body(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_body(b);
`ifdef USART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(1'b1);
    endtask

`ifdef USART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] b);
        send_body(b);
        send_bit(~^b);
        send_bit(1'b1);
    endtask
`endif

    task automatic pulse_ack();
        bus.data_ack = 1'b1;
        @(negedge clock);
        bus.data_ack = 1'b0;
    endtask

    // sends the bytes with idle gaps while a consumer acks every byte as soon as it appears
    task automatic send_acked(input logic [7:0] bytes[$], input int max_gap, input string tag);
        logic [7:0] got[$];
        logic       snd_done;
        int         budget;
        snd_done = 1'b0;
        budget   = 20000;
        fork
            begin
                foreach (bytes[i]) begin
                    repeat ($urandom_range(0, max_gap)) @(negedge clock);
                    send_frame(bytes[i]);
                end
                snd_done = 1'b1;
            end
            begin
                while ((!snd_done || bus.data_ready || bus.data_ack) && budget > 0) begin
                    @(negedge clock);
                    budget--;
                    if (bus.data_ack) bus.data_ack = 1'b0;
                    else if (bus.data_ready) begin
                        got.push_back(bus.data);
                        bus.data_ack = 1'b1;
                    end
                end
            end
        join
        check({tag, "_budget"}, 32'(budget > 0), 32'd1);
        check({tag, "_count"}, 32'(got.size()), 32'(bytes.size()));
        foreach (bytes[i])
            if (i < got.size()) check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, bytes[i]});
        check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        reset        = 1'b1;
        rx           = 1'b1;
        bus.data_ack = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_ready", 32'(bus.data_ready), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_fe", 32'(bus.frame_error), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        fe_base = fe_seen;
        fork
            send_frame(8'h55);
            begin
                repeat (LAT - 1) @(negedge clock);
                check("lat_before", 32'(bus.data_ready), 32'd0);
                @(negedge clock);
                check("lat_at", 32'(bus.data_ready), 32'd1);
            end
        join
        check("f55_data", {24'd0, bus.data}, 32'h55);
        check("f55_fe", 32'(fe_seen - fe_base), 32'd0);
        check("f55_overrun", 32'(bus.overrun), 32'd0);
        pulse_ack();
        check("f55_acked", 32'(bus.data_ready), 32'd0);

        q = '{8'hA3, 8'h0F};
        send_acked(q, 0, "b2b");

        send_frame(8'h11);
        send_frame(8'h22);
        check("ovr_data", {24'd0, bus.data}, 32'h22);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        check("ovr_ready", 32'(bus.data_ready), 32'd1);
        pulse_ack();
        check("ovr_ack_ready", 32'(bus.data_ready), 32'd0);
        check("ovr_ack_flag", 32'(bus.overrun), 32'd0);
        check("ovr_ack_data", {24'd0, bus.data}, 32'h22);

        fe_base = fe_seen;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_busy", 32'(bus.busy), 32'd0);
        check("glitch_ready", 32'(bus.data_ready), 32'd0);
        check("glitch_fe", 32'(fe_seen - fe_base), 32'd0);

        rx = 1'b0;
        repeat (20 * DIV) @(negedge clock);
        check("break_fe", 32'(fe_seen - fe_base), 32'd1);
        check("break_busy", 32'(bus.busy), 32'd1);
        check("break_ready", 32'(bus.data_ready), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clock);
        check("break_exit", 32'(bus.busy), 32'd0);

        send_bit(1'b0);
        rx = 1'b1;
        repeat (4 * DIV + DIV / 2) @(negedge clock);
        check("midrst_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (5 * DIV) @(negedge clock);
        check("midrst_ready", 32'(bus.data_ready), 32'd0);
        send_frame(8'h3C);
        check("midrst_data", {24'd0, bus.data}, 32'h3C);
        check("midrst_ovr", 32'(bus.overrun), 32'd0);
        pulse_ack();

        q = {};
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(0, 255)));
        send_acked(q, 20, "rand");

`ifdef USART_RX_PARITY_EN
        fe_base = fe_seen;
        send_frame_badpar(8'h07);
        repeat (4) @(negedge clock);
        check("par_bad_fe", 32'(fe_seen - fe_base), 32'd1);
        check("par_bad_ready", 32'(bus.data_ready), 32'd0);
        send_frame(8'h07);
        check("par_good_data", {24'd0, bus.data}, 32'h07);
        check("par_good_ready", 32'(bus.data_ready), 32'd1);
        pulse_ack();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
